// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the parametrised systolic-array controller:
//   state_t   - controller FSM encoding (IDLE=0, LOAD=1, WAIT=2, ROLL=3)
//   idx_width - width of an index spanning 0..n-1 (never less than 1 bit)
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        ROLL = 2'd3
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_ctrl_param_if.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_param_if
// Control handshake between the top-level sequencer and the systolic
// controller.
//   tpu_start  master->slave  start request
//   cfg_sets   master->slave  number of data sets minus 1
//   stall      master->slave  pipeline freeze request
//   abort      master->slave  synchronous cancel
//   busy       slave->master  controller not idle
//   tpu_done   slave->master  single-cycle completion pulse
// Modports: master (requester side), slave (controller side).
// -----------------------------------------------------------------------------
interface systolic_ctrl_param_if #(
    parameter int unsigned SET_W = 2
);
    logic             tpu_start;
    logic [SET_W-1:0] cfg_sets;
    logic             stall;
    logic             abort;
    logic             busy;
    logic             tpu_done;

    modport master (
        output tpu_start, cfg_sets, stall, abort,
        input  busy, tpu_done
    );

    modport slave (
        input  tpu_start, cfg_sets, stall, abort,
        output busy, tpu_done
    );
endinterface

// File: rtl/systolic_out_cnt.sv
// -----------------------------------------------------------------------------
// systolic_out_cnt
// Write-out position counter pair: matrix_index counts output rows and wraps
// at ARRAY_SIZE-1, advancing data_set on each wrap.
//   clk, srstn    clock / synchronous active-low reset
//   en            one write happens this cycle
//   clr           force both counters to 0 (wins over en)
//   last_set      index of the final data set of the run
//   matrix_index  current output row
//   data_set      current output set
//   final_write   this write is the last one of the run (combinational)
// -----------------------------------------------------------------------------
module systolic_out_cnt
    import systolic_pkg::*;
#(
    parameter  int unsigned ARRAY_SIZE = 16,
    parameter  int unsigned SET_W      = 2,
    localparam int unsigned IDX_W      = idx_width(ARRAY_SIZE)
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             en,
    input  logic             clr,
    input  logic [SET_W-1:0] last_set,
    output logic [IDX_W-1:0] matrix_index,
    output logic [SET_W-1:0] data_set,
    output logic             final_write
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ARRAY_SIZE - 1);

    logic row_wrap;

    assign row_wrap    = (matrix_index == IDX_MAX);
    assign final_write = en && row_wrap && (data_set == last_set);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            matrix_index <= '0;
            data_set     <= '0;
        end else if (clr || final_write) begin
            matrix_index <= '0;
            data_set     <= '0;
        end else if (en) begin
            if (row_wrap) begin
                matrix_index <= '0;
                data_set     <= data_set + 1'b1;
            end else begin
                matrix_index <= matrix_index + 1'b1;
            end
        end
    end
endmodule

// File: rtl/systolic_ctrl_param.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_param
// Parametrised controller for the output-stationary systolic array: sequences
// operand load (LOAD, WAIT), the rolling phase (ROLL) and result write-out for
// cfg_sets+1 output data sets, with stall, abort and busy.
// Ports:
//   clk, srstn          clock / synchronous active-low reset
//   ctrl (slave)        tpu_start, cfg_sets, stall, abort in; busy, tpu_done out
//   sram_write_enable   output SRAM write strobe (combinational)
//   addr_serial_num     operand address index, saturating
//   alu_start           array shift/multiply enable (combinational)
//   cycle_num           ROLL-phase cycle counter, saturating
//   matrix_index        output row being written
//   data_set            output set being written
//   perf_cycles         cycles from start accept to tpu_done, saturating
//                       (present only with SYSTOLIC_CTRL_PERF_EN defined)
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN
// -----------------------------------------------------------------------------
module systolic_ctrl_param
    import systolic_pkg::*;
#(
    parameter  int unsigned ARRAY_SIZE = 16,
    parameter  int unsigned ADDR_W     = 7,
    parameter  int unsigned SET_W      = 2,
    parameter  int unsigned CYC_W      = 9,
    localparam int unsigned IDX_W      = idx_width(ARRAY_SIZE)
) (
    input  logic                  clk,
    input  logic                  srstn,
    systolic_ctrl_param_if.slave  ctrl,
    output logic                  sram_write_enable,
    output logic [ADDR_W-1:0]     addr_serial_num,
    output logic                  alu_start,
    output logic [CYC_W-1:0]      cycle_num,
    output logic [IDX_W-1:0]      matrix_index,
    output logic [SET_W-1:0]      data_set
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);
    localparam logic [CYC_W-1:0] WR_START = CYC_W'(ARRAY_SIZE + 1);

    state_t           state_q, state_d;
    logic [SET_W-1:0] sets_q;
    logic             done_q;
    logic             start_acc;
    logic             final_write;
    logic             cnt_clr;

    assign ctrl.busy     = (state_q != IDLE);
    assign ctrl.tpu_done = done_q;
    assign cnt_clr       = ctrl.abort || (state_q == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!srstn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ctrl.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start_acc)     state_d = LOAD;
                LOAD: if (!ctrl.stall)   state_d = WAIT;
                WAIT: if (!ctrl.stall)   state_d = ROLL;
                ROLL: if (final_write)   state_d = IDLE;
                default:                 state_d = IDLE;
            endcase
        end
    end

    // Output logic. A start coinciding with tpu_done is refused so the next
    // run is accepted one cycle after completion.
    always_comb begin
        start_acc         = (state_q == IDLE) && ctrl.tpu_start && !done_q && !ctrl.abort;
        alu_start         = (state_q == ROLL) && !ctrl.stall;
        sram_write_enable = (state_q == ROLL) && (cycle_num >= WR_START) && !ctrl.stall;
    end

    // Address / cycle counters, set latch and done pulse
    always_ff @(posedge clk) begin
        if (!srstn) begin
            addr_serial_num <= '0;
            cycle_num       <= '0;
            sets_q          <= '0;
            done_q          <= 1'b0;
        end else if (ctrl.abort) begin
            addr_serial_num <= '0;
            cycle_num       <= '0;
            done_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    addr_serial_num <= '0;
                    cycle_num       <= '0;
                    if (start_acc) sets_q <= ctrl.cfg_sets;
                end
                LOAD: if (!ctrl.stall) addr_serial_num <= ADDR_W'(1);
                WAIT: if (!ctrl.stall) addr_serial_num <= ADDR_W'(2);
                ROLL: begin
                    if (final_write) begin
                        addr_serial_num <= '0;
                        cycle_num       <= '0;
                        done_q          <= 1'b1;
                    end else if (!ctrl.stall) begin
                        if (cycle_num != '1)       cycle_num       <= cycle_num + 1'b1;
                        if (addr_serial_num != '1) addr_serial_num <= addr_serial_num + 1'b1;
                    end
                end
                default: begin
                    addr_serial_num <= '0;
                    cycle_num       <= '0;
                end
            endcase
        end
    end

    systolic_out_cnt #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .SET_W      (SET_W)
    ) u_out_cnt (
        .clk          (clk),
        .srstn        (srstn),
        .en           (sram_write_enable),
        .clr          (cnt_clr),
        .last_set     (sets_q),
        .matrix_index (matrix_index),
        .data_set     (data_set),
        .final_write  (final_write)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    // Loading 1 on accept counts the accept cycle itself, so the value seen
    // alongside tpu_done equals done cycle minus accept cycle.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= 32'd1;
        end else if ((state_q != IDLE) && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`endif
endmodule
